// File: rtl/game_sequencer.sv
// Per-frame game controller: sequences updater and pixel drawer, owns ball/platform/score state.
// Optional GAME_SEQUENCER_HISCORE_EN adds a high_score output that tracks the best score since reset.
module game_sequencer #(
   parameter int          FRAME_DIV  = 833333,
   parameter logic [7:0]  BALL_START = 8'd20,
   parameter logic [31:0] PLAT_POS   = 32'h8C_78_64_50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_n,
   input  logic [3:0]  keys_in,
   output logic [1:0]  statesig,
   output logic [3:0]  keys_out,
   output logic [7:0]  curr_ball,
   output logic [31:0] position_plats,
   output logic [11:0] color_plats,
   output logic [2:0]  color_ball,
   output logic [15:0] curr_score,
   input  logic [7:0]  upd_prev_ball,
   input  logic [7:0]  upd_new_ball,
   input  logic [11:0] upd_color_plats,
   input  logic [2:0]  upd_color_ball,
   input  logic        upd_gameover,
   input  logic [15:0] upd_score,
   output logic        draw_req,
   output logic        draw_erase,
   output logic [7:0]  draw_y,
   input  logic        draw_done,
   output logic        game_over
`ifdef GAME_SEQUENCER_HISCORE_EN
  ,output logic [15:0] high_score
`endif
);

   localparam int            CW        = $clog2(FRAME_DIV);
   localparam logic [CW-1:0] CNT_MAX   = CW'(FRAME_DIV - 1);
   localparam logic [11:0]   PLAT_COL0 = 12'b001010100111;
   localparam logic [2:0]    BALL_COL0 = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_WAIT, S_UPDATE, S_LATCH, S_ERASE, S_DRAW, S_OVER
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      start_sync;
   logic            start_prev;
   logic            start_press;
   logic [3:0]      key_s1, key_s2;
   logic [3:0]      key_latch;
   logic [CW-1:0]   cnt;
   logic [7:0]      prev_ball;
   logic            gap;
   logic [3:0]      key_n;
   logic            key_one;

   assign position_plats = PLAT_POS;

   // start synchroniser resets to "pressed" so a button held through reset never looks like a new press
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_sync <= 2'b00;
         start_prev <= 1'b0;
         key_s1     <= 4'hF;
         key_s2     <= 4'hF;
      end else begin
         start_sync <= {start_sync[0], start_n};
         start_prev <= start_sync[1];
         key_s1     <= keys_in;
         key_s2     <= key_s1;
      end
   end

   assign start_press = start_prev & ~start_sync[1];
   assign key_n       = ~key_s2;
   assign key_one     = (key_n != 4'd0) && ((key_n & (key_n - 4'd1)) == 4'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      statesig   = 2'b00;
      keys_out   = 4'hF;
      draw_req   = 1'b0;
      draw_erase = 1'b0;
      draw_y     = 8'd0;
      game_over  = 1'b0;
      state_d    = state_q;
      case (state_q)
         S_IDLE:   if (start_press) state_d = S_INIT;
         S_INIT:   state_d = S_DRAW;
         S_WAIT: begin
            statesig = 2'b01;
            if (cnt == CNT_MAX) state_d = S_UPDATE;
         end
         S_UPDATE: begin
            statesig = 2'b11;
            keys_out = key_latch;
            state_d  = S_LATCH;
         end
         S_LATCH: begin
            statesig = 2'b01;
            state_d  = upd_gameover ? S_OVER : S_ERASE;
         end
         S_ERASE: begin
            statesig   = 2'b10;
            draw_req   = 1'b1;
            draw_erase = 1'b1;
            draw_y     = prev_ball;
            if (draw_req && draw_done) state_d = S_DRAW;
         end
         S_DRAW: begin
            // one idle cycle after an erase so the drawer sees a fresh request
            statesig = 2'b10;
            draw_req = ~gap;
            draw_y   = curr_ball;
            if (draw_req && draw_done) state_d = S_WAIT;
         end
         S_OVER: begin
            game_over = 1'b1;
            if (start_press) state_d = S_INIT;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         curr_ball   <= BALL_START;
         color_plats <= PLAT_COL0;
         color_ball  <= BALL_COL0;
         curr_score  <= 16'd0;
         prev_ball   <= 8'd0;
         cnt         <= '0;
         key_latch   <= 4'hF;
         gap         <= 1'b0;
      end else begin
         gap <= (state_q == S_ERASE) && draw_done;
         if (state_q == S_WAIT) cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
         else                   cnt <= '0;
         if (state_q == S_UPDATE)
            key_latch <= 4'hF;
         else if (state_q == S_WAIT && key_latch == 4'hF && key_one)
            key_latch <= key_s2;
         if (state_q == S_INIT) begin
            curr_ball   <= BALL_START;
            color_plats <= PLAT_COL0;
            color_ball  <= BALL_COL0;
            curr_score  <= 16'd0;
         end else if (state_q == S_LATCH) begin
            curr_ball   <= upd_new_ball;
            color_plats <= upd_color_plats;
            color_ball  <= upd_color_ball;
            curr_score  <= upd_score;
            prev_ball   <= upd_prev_ball;
         end
      end
   end

`ifdef GAME_SEQUENCER_HISCORE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                         high_score <= 16'd0;
      else if (state_q == S_LATCH && upd_score > high_score) high_score <= upd_score;
   end
`endif

endmodule
